// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered integer ALU.
//   alu_op_t  - 3-bit operation select encoding carried on funct
//   ALU_WIDTH - default operand/result width
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  typedef enum logic [2:0] {
    SUM         = 3'd0,
    SHIFT_LEFT  = 3'd1,
    SUB         = 3'd2,
    LOAD        = 3'd3,
    XOR         = 3'd4,
    SHIFT_RIGHT = 3'd5,
    NOT         = 3'd6,
    AND         = 3'd7
  } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
//   funct    - operation select (alu_op_t encoding)
//   a, b     - two's complement operands
//   result   - operation result
//   overflow - signed overflow of SUM/SUB, 0 otherwise
//   negative - result MSB
//   zero     - result == 0
//   equal, greater, less - signed compare of a and b, independent of funct
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic             equal,
  output logic             greater,
  output logic             less
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_result;
  logic             w_overflow;

  // Only the low bits of b select the shift distance; the rest are ignored.
  assign w_shamt = b[SHW-1:0];
  assign w_sum   = a + b;
  assign w_diff  = a - b;

  always_comb begin
    w_result   = '0;
    w_overflow = 1'b0;
    case (alu_op_t'(funct))
      SUM: begin
        w_result   = w_sum;
        // Same-sign operands whose sum flips sign.
        w_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      SHIFT_LEFT:  w_result = a << w_shamt;
      SUB: begin
        w_result   = w_diff;
        // Opposite-sign operands whose difference leaves a's sign.
        w_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      LOAD:        w_result = a;
      XOR:         w_result = a ^ b;
      SHIFT_RIGHT: w_result = a >> w_shamt;
      NOT:         w_result = ~a;
      AND:         w_result = a & b;
      default:     w_result = '0;
    endcase
  end

  assign result   = w_result;
  assign overflow = w_overflow;
  assign negative = w_result[WIDTH-1];
  assign zero     = (w_result == '0);
  assign equal    = (a == b);
  assign greater  = ($signed(a) > $signed(b));
  assign less     = ($signed(a) < $signed(b));

endmodule

// File: rtl/alu.sv
// alu: registered integer ALU, one result per clock, 1-cycle latency.
//   clk      - rising-edge clock
//   reset    - synchronous active-high reset, clears every output (zero too)
//   funct    - operation select (alu_op_t encoding)
//   a, b     - two's complement operands
//   result, overflow, negative, zero, equal, greater, less - registered outputs
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic             equal,
  output logic             greater,
  output logic             less
);

  logic [WIDTH-1:0] w_result;
  logic             w_overflow, w_negative, w_zero, w_equal, w_greater, w_less;

  logic [WIDTH-1:0] r_result;
  logic             r_overflow, r_negative, r_zero, r_equal, r_greater, r_less;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .funct    (funct),
    .a        (a),
    .b        (b),
    .result   (w_result),
    .overflow (w_overflow),
    .negative (w_negative),
    .zero     (w_zero),
    .equal    (w_equal),
    .greater  (w_greater),
    .less     (w_less)
  );

  // Reset clears zero as well, so zero reads 0 during reset despite result==0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_negative <= 1'b0;
      r_zero     <= 1'b0;
      r_equal    <= 1'b0;
      r_greater  <= 1'b0;
      r_less     <= 1'b0;
    end else begin
      r_result   <= w_result;
      r_overflow <= w_overflow;
      r_negative <= w_negative;
      r_zero     <= w_zero;
      r_equal    <= w_equal;
      r_greater  <= w_greater;
      r_less     <= w_less;
    end
  end

  assign result   = r_result;
  assign overflow = r_overflow;
  assign negative = r_negative;
  assign zero     = r_zero;
  assign equal    = r_equal;
  assign greater  = r_greater;
  assign less     = r_less;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for alu with a cycle-accurate reference model.
module tb_alu;

  localparam int W = 64;
  localparam logic signed [W:0] SMAX = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [W:0] SMIN = -65'sh0_8000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   funct;
  logic [W-1:0] a, b;
  logic [W-1:0] result;
  logic         overflow, negative, zero, equal, greater, less;

  alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .funct    (funct),
    .a        (a),
    .b        (b),
    .result   (result),
    .overflow (overflow),
    .negative (negative),
    .zero     (zero),
    .equal    (equal),
    .greater  (greater),
    .less     (less)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: arithmetic on wide signed integers, outputs latched per edge.
  logic [W-1:0] exp_result;
  logic         exp_overflow, exp_negative, exp_zero, exp_equal, exp_greater, exp_less;
  logic         model_valid = 1'b0;

  always @(posedge clk) begin
    logic signed [W:0] wide;
    int unsigned amt;
    model_valid = 1'b1;
    if (reset) begin
      exp_result = '0; exp_overflow = 0; exp_negative = 0; exp_zero = 0;
      exp_equal = 0; exp_greater = 0; exp_less = 0;
    end else begin
      amt = int'(b % 64);
      exp_overflow = 1'b0;
      case (funct)
        3'd0: begin
          wide = $signed(a) + $signed(b);
          exp_result = wide[W-1:0];
          exp_overflow = (wide > SMAX) || (wide < SMIN);
        end
        3'd1: exp_result = a << amt;
        3'd2: begin
          wide = $signed(a) - $signed(b);
          exp_result = wide[W-1:0];
          exp_overflow = (wide > SMAX) || (wide < SMIN);
        end
        3'd3: exp_result = a;
        3'd4: exp_result = a ^ b;
        3'd5: exp_result = a >> amt;
        3'd6: exp_result = ~a;
        default: exp_result = a & b;
      endcase
      exp_negative = ($signed(exp_result) < 0);
      exp_zero     = (exp_result == 0);
      exp_equal    = (a == b);
      exp_greater  = ($signed(a) > $signed(b));
      exp_less     = ($signed(a) < $signed(b));
    end
  end

  // Every cycle, mid-period: DUT outputs must match the model.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("m_result",   result,   exp_result);
      chk("m_overflow", {63'd0, overflow}, {63'd0, exp_overflow});
      chk("m_negative", {63'd0, negative}, {63'd0, exp_negative});
      chk("m_zero",     {63'd0, zero},     {63'd0, exp_zero});
      chk("m_equal",    {63'd0, equal},    {63'd0, exp_equal});
      chk("m_greater",  {63'd0, greater},  {63'd0, exp_greater});
      chk("m_less",     {63'd0, less},     {63'd0, exp_less});
    end
  end

  // Apply one op for exactly one cycle; returns just after the capturing edge.
  task automatic step(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    reset = 1'b0; funct = f; a = x; b = y;
    @(posedge clk);
    #1;
    $display("op funct=%0d a=%h b=%h -> result=%h ov=%b n=%b z=%b eq=%b gt=%b lt=%b",
             f, x, y, result, overflow, negative, zero, equal, greater, less);
  endtask

  task automatic flags(input string name, input logic [5:0] exp6);
    chk(name, {58'd0, overflow, negative, zero, equal, greater, less}, {58'd0, exp6});
  endtask

  initial begin
    reset = 1'b1; funct = 3'd0; a = 64'd5; b = 64'd5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 64'd0);
    // flags order: ov neg zero eq gt lt
    flags("rst_flags", 6'b000000);

    step(3'd0, 64'd5, 64'd5);                 chk("rel_res", result, 64'd10);
                                              flags("rel_flags", 6'b000100);
    step(3'd0, 64'd12, 64'd25);               chk("sum_res", result, 64'd37);
                                              flags("sum_flags", 6'b000001);
    step(3'd2, 64'd12, 64'd25);               chk("sub_res", result, 64'hFFFF_FFFF_FFFF_FFF3);
                                              flags("sub_flags", 6'b010001);
    step(3'd7, 64'd12, 64'd25);               chk("and_res", result, 64'd8);
    step(3'd4, 64'd12, 64'd25);               chk("xor_res", result, 64'd21);
    step(3'd6, 64'd0, 64'd9);                 chk("not_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
                                              flags("not_flags", 6'b010001);
    step(3'd3, -64'sd7, 64'd100);             chk("load_res", result, 64'hFFFF_FFFF_FFFF_FFF9);
    step(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd3);
                                              chk("sumov_res", result, 64'h8000_0000_0000_0002);
                                              flags("sumov_flags", 6'b110010);
    step(3'd2, 64'h8000_0000_0000_0000, 64'd3);
                                              chk("subov_res", result, 64'h7FFF_FFFF_FFFF_FFFD);
                                              flags("subov_flags", 6'b100001);
    step(3'd2, 64'd54, 64'd54);               chk("subz_res", result, 64'd0);
                                              flags("subz_flags", 6'b001100);
    step(3'd1, 64'd1, 64'd63);                chk("shl_res", result, 64'h8000_0000_0000_0000);
                                              flags("shl_flags", 6'b010001);
    step(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64);
                                              chk("shr0_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
    step(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4);
                                              chk("shr4_res", result, 64'h0FFF_FFFF_FFFF_FFFF);
    // Overflow stays 0 for non-arithmetic ops even with overflow-prone operands.
    step(3'd4, 64'h7FFF_FFFF_FFFF_FFFF, 64'd3);
                                              chk("xor_ov", {63'd0, overflow}, 64'd0);
    step(3'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
                                              chk("sumneg_res", result, 64'd0);
                                              flags("sumneg_flags", 6'b101100);
    // Re-enter reset mid-stream.
    @(negedge clk);
    reset = 1'b1; funct = 3'd6; a = 64'd0;
    @(posedge clk); #1;
    chk("rst2_result", result, 64'd0);
    flags("rst2_flags", 6'b000000);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
